// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared encodings and constants for pipe_ctrl
//
// Purpose: FSM state encoding and pipeline constants used by the control slice.
// Ports  : none (package).
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_HOLD    = 2'd1,
      ST_LDSTALL = 2'd2,
      ST_FLUSH   = 2'd3
   } state_t;

   // addi x0, x0, 0 -- what a flushed if_id presents to decode
   localparam logic [31:0] NOP       = 32'h00000013;
   localparam logic [31:0] ZERO_WORD = 32'h00000000;
   localparam logic [4:0]  ZERO_REG  = 5'd0;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// rtl/pipe_ctrl_hazard_detect.sv - combinational load-use hazard compare
//
// Purpose: flags when the instruction in ID reads the rd of a load still in EX.
// Ports  : i_rs1_addr/i_rs2_addr/i_rs1_used/i_rs2_used  ID source operands
//          i_ex_rd_addr/i_ex_reg_wen/i_ex_is_load        EX destination
//          o_ld_use                                       hazard present
module pipe_ctrl_hazard_detect
   import pipe_ctrl_pkg::*;
(
   input  logic [4:0] i_rs1_addr,
   input  logic [4:0] i_rs2_addr,
   input  logic       i_rs1_used,
   input  logic       i_rs2_used,
   input  logic [4:0] i_ex_rd_addr,
   input  logic       i_ex_reg_wen,
   input  logic       i_ex_is_load,
   output logic       o_ld_use
);

   logic w_rs1_hit;
   logic w_rs2_hit;

   assign w_rs1_hit = i_rs1_used & (i_rs1_addr == i_ex_rd_addr);
   assign w_rs2_hit = i_rs2_used & (i_rs2_addr == i_ex_rd_addr);

   // x0 is never really written, so a load to x0 cannot create a hazard
   assign o_ld_use = i_ex_is_load & i_ex_reg_wen & (i_ex_rd_addr != ZERO_REG)
                   & (w_rs1_hit | w_rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush/redirect control for the RV32 core
//
// Purpose: drives PC, if_id and id_ex hold/flush controls from EX redirects,
//          EX multi-cycle busy requests and load-use hazards against ID.
//          Optional perf counters are built when PIPE_CTRL_PERF_EN is defined.
// Ports  : clk, rst (sync, active-high)
//          id_rs1/rs2_addr_i, id_rs1/rs2_used_i     ID operands
//          ex_rd_addr_i, ex_reg_wen_i, ex_is_load_i EX destination
//          jump_en_i, jump_addr_i, hold_req_i       EX requests
//          jump_en_o, jump_addr_o                    PC redirect
//          pc_hold_o, if_id_hold_o, if_id_flush_o,
//          id_ex_hold_o, id_ex_flush_o               stage controls
//          hold_timeout_o                            sticky hold overrun flag
//          stall_cnt_o, flush_cnt_o                  (PIPE_CTRL_PERF_EN only)
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int HOLD_MAX = 64,
   parameter int ADDR_W   = 32
)(
   input  logic              clk,
   input  logic              rst,
   input  logic [4:0]        id_rs1_addr_i,
   input  logic [4:0]        id_rs2_addr_i,
   input  logic              id_rs1_used_i,
   input  logic              id_rs2_used_i,
   input  logic [4:0]        ex_rd_addr_i,
   input  logic              ex_reg_wen_i,
   input  logic              ex_is_load_i,
   input  logic              jump_en_i,
   input  logic [ADDR_W-1:0] jump_addr_i,
   input  logic              hold_req_i,
   output logic              jump_en_o,
   output logic [ADDR_W-1:0] jump_addr_o,
   output logic              pc_hold_o,
   output logic              if_id_hold_o,
   output logic              if_id_flush_o,
   output logic              id_ex_hold_o,
   output logic              id_ex_flush_o,
   output logic              hold_timeout_o
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [31:0]       stall_cnt_o,
   output logic [31:0]       flush_cnt_o
`endif
);

   localparam int CNT_W = $clog2(HOLD_MAX + 1);

   state_t           r_state;
   state_t           w_next_state;
   logic [CNT_W-1:0] r_hold_cnt;
   logic             r_timeout;
   logic             w_ld_use_raw;
   logic             w_ld_use;

   pipe_ctrl_hazard_detect u_hazard (
      .i_rs1_addr   (id_rs1_addr_i),
      .i_rs2_addr   (id_rs2_addr_i),
      .i_rs1_used   (id_rs1_used_i),
      .i_rs2_used   (id_rs2_used_i),
      .i_ex_rd_addr (ex_rd_addr_i),
      .i_ex_reg_wen (ex_reg_wen_i),
      .i_ex_is_load (ex_is_load_i),
      .o_ld_use     (w_ld_use_raw)
   );

   // After a stall the ID slot behind the load is a bubble, and after a flush
   // it is a NOP; neither can legitimately depend on the load in EX.
   assign w_ld_use = w_ld_use_raw & (r_state != ST_LDSTALL) & (r_state != ST_FLUSH);

   // Priority: hold > jump > load-use > none
   always_comb begin
      jump_en_o     = 1'b0;
      jump_addr_o   = ADDR_W'(ZERO_WORD);
      pc_hold_o     = 1'b0;
      if_id_hold_o  = 1'b0;
      if_id_flush_o = 1'b0;
      id_ex_hold_o  = 1'b0;
      id_ex_flush_o = 1'b0;
      w_next_state  = ST_RUN;
      if (!rst) begin
         if (hold_req_i) begin
            pc_hold_o    = 1'b1;
            if_id_hold_o = 1'b1;
            id_ex_hold_o = 1'b1;
            w_next_state = ST_HOLD;
         end else if (jump_en_i) begin
            jump_en_o     = 1'b1;
            jump_addr_o   = jump_addr_i;
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
            w_next_state  = ST_FLUSH;
         end else if (w_ld_use) begin
            pc_hold_o     = 1'b1;
            if_id_hold_o  = 1'b1;
            id_ex_flush_o = 1'b1;
            w_next_state  = ST_LDSTALL;
         end
      end
   end

   assign hold_timeout_o = r_timeout;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_RUN;
         r_hold_cnt <= '0;
         r_timeout  <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (hold_req_i) begin
            // counter saturates; the flag latches once a hold outlasts HOLD_MAX
            if (r_hold_cnt == CNT_W'(HOLD_MAX))
               r_timeout <= 1'b1;
            else
               r_hold_cnt <= r_hold_cnt + CNT_W'(1);
         end else begin
            r_hold_cnt <= '0;
         end
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] r_stall_cnt;
   logic [31:0] r_flush_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (pc_hold_o) r_stall_cnt <= r_stall_cnt + 32'd1;
         if (jump_en_o) r_flush_cnt <= r_flush_cnt + 32'd1;
      end
   end

   assign stall_cnt_o = r_stall_cnt;
   assign flush_cnt_o = r_flush_cnt;
`endif

endmodule
